// File: rtl/hilo_pkg.sv
// hilo_pkg: shared encodings, state type and default latencies for the HI/LO stage.
package hilo_pkg;

    localparam int unsigned OP_W = 2;

    localparam logic [OP_W-1:0] OP_NONE = 2'b00;
    localparam logic [OP_W-1:0] OP_MUL  = 2'b01;
    localparam logic [OP_W-1:0] OP_DIV  = 2'b10;

    localparam int unsigned DEFAULT_DATA_WIDTH  = 32;
    localparam int unsigned DEFAULT_DIV_LATENCY = 4;
    localparam int unsigned DEFAULT_MUL_LATENCY = 2;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    // Larger of two latencies, used to size the settle counter.
    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/hilo_lat_counter.sv
// hilo_lat_counter: loadable down-counter that times out the producer settle latency.
// The zero flag is registered alongside the count so it is available at the edge.
module hilo_lat_counter #(
    parameter int unsigned CNT_W = 3
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             load,
    input  logic [CNT_W-1:0] load_value,
    input  logic             dec,
    output logic [CNT_W-1:0] value,
    output logic             zero
);

    // Count register: clear wins, then load, then decrement (never below zero).
    always_ff @(posedge clock) begin
        if (clear) begin
            value <= '0;
            zero  <= 1'b1;
        end else if (load) begin
            value <= load_value;
            zero  <= (load_value == '0);
        end else if (dec && (value != '0)) begin
            value <= value - CNT_W'(1);
            zero  <= (value == CNT_W'(1));
        end
    end

endmodule

// File: rtl/hilo_unit.sv
// hilo_unit: HI/LO result capture stage behind the multiplier and divider.
// Counts out the producer settle latency, then latches {hi, lo} from z_in, and
// interlocks MFHI/MFLO/MTHI/MTLO against an in-flight operation via stall.
// Optional feature macro: HILO_DIV0_FLAG_EN adds m_in and a sticky div0 flag.
module hilo_unit
    import hilo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = DEFAULT_DATA_WIDTH,
    parameter int unsigned DIV_LATENCY = DEFAULT_DIV_LATENCY,
    parameter int unsigned MUL_LATENCY = DEFAULT_MUL_LATENCY
) (
    input  logic                    clock,
    input  logic                    clear,
    input  logic                    start,
    input  logic [OP_W-1:0]         op,
    input  logic [2*DATA_WIDTH-1:0] z_in,
    input  logic                    mt_hi,
    input  logic                    mt_lo,
    input  logic [DATA_WIDTH-1:0]   mt_data,
    input  logic                    rd_hi,
    input  logic                    rd_lo,
    output logic [DATA_WIDTH-1:0]   hi_out,
    output logic [DATA_WIDTH-1:0]   lo_out,
    output logic                    busy,
    output logic                    done,
    output logic                    stall
`ifdef HILO_DIV0_FLAG_EN
    ,
    input  logic [DATA_WIDTH-1:0]   m_in,
    output logic                    div0
`endif
);

    localparam int unsigned CNT_W = $clog2(max_u(DIV_LATENCY, MUL_LATENCY)) + 1;

    state_t           state;
    state_t           state_next;
    logic             cnt_load;
    logic             cnt_dec;
    logic             cnt_zero;
    logic             capture;
    logic [CNT_W-1:0] cnt_load_value;
    logic [CNT_W-1:0] cnt_value;

    // State register.
    always_ff @(posedge clock) begin
        if (clear) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and counter control; reserved op launches nothing.
    always_comb begin
        state_next     = state;
        cnt_load       = 1'b0;
        cnt_dec        = 1'b0;
        capture        = 1'b0;
        cnt_load_value = CNT_W'(DIV_LATENCY - 1);
        if (op == OP_MUL) begin
            cnt_load_value = CNT_W'(MUL_LATENCY - 1);
        end
        case (state)
            IDLE: begin
                if (start && ((op == OP_MUL) || (op == OP_DIV))) begin
                    state_next = BUSY;
                    cnt_load   = 1'b1;
                end
            end
            BUSY: begin
                if (cnt_zero) begin
                    capture    = 1'b1;
                    state_next = IDLE;
                end else begin
                    cnt_dec = (cnt_value != '0);
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    hilo_lat_counter #(
        .CNT_W (CNT_W)
    ) u_lat_counter (
        .clock      (clock),
        .clear      (clear),
        .load       (cnt_load),
        .load_value (cnt_load_value),
        .dec        (cnt_dec),
        .value      (cnt_value),
        .zero       (cnt_zero)
    );

    // HI/LO and status registers: capture overrides, MT writes only land in IDLE.
    always_ff @(posedge clock) begin
        if (clear) begin
            hi_out <= '0;
            lo_out <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            busy <= (state_next == BUSY);
            done <= capture;
            if (capture) begin
                hi_out <= z_in[2*DATA_WIDTH-1:DATA_WIDTH];
                lo_out <= z_in[DATA_WIDTH-1:0];
            end else if (state == IDLE) begin
                if (mt_hi) begin
                    hi_out <= mt_data;
                end
                if (mt_lo) begin
                    lo_out <= mt_data;
                end
            end
        end
    end

    assign stall = busy & (rd_hi | rd_lo | mt_hi | mt_lo);

`ifdef HILO_DIV0_FLAG_EN
    logic [OP_W-1:0] op_q;
    logic            div0_pend;

    // Latch op and divisor-is-zero at launch; update sticky div0 on DIV capture.
    always_ff @(posedge clock) begin
        if (clear) begin
            op_q      <= OP_NONE;
            div0_pend <= 1'b0;
            div0      <= 1'b0;
        end else begin
            if (cnt_load) begin
                op_q      <= op;
                div0_pend <= (m_in == '0);
            end
            if (capture && (op_q == OP_DIV)) begin
                div0 <= div0_pend;
            end
        end
    end
`endif

endmodule

// File: tb/tb_hilo_unit.sv
// tb_hilo_unit: self-checking bench for hilo_unit with a transaction-level HI/LO model.
// Optional feature macro: HILO_DIV0_FLAG_EN (bench follows the same build setting).
module tb_hilo_unit;

    localparam int unsigned W     = 32;
    localparam int unsigned DIV_L = 4;
    localparam int unsigned MUL_L = 2;
    localparam logic [1:0] T_NONE = 2'b00;
    localparam logic [1:0] T_MUL  = 2'b01;
    localparam logic [1:0] T_DIV  = 2'b10;
    localparam logic [1:0] T_RSV  = 2'b11;

    logic           clock = 1'b0;
    logic           clear;
    logic           start;
    logic [1:0]     op;
    logic [2*W-1:0] z_in;
    logic           mt_hi;
    logic           mt_lo;
    logic [W-1:0]   mt_data;
    logic           rd_hi;
    logic           rd_lo;
    logic [W-1:0]   hi_out;
    logic [W-1:0]   lo_out;
    logic           busy;
    logic           done;
    logic           stall;
`ifdef HILO_DIV0_FLAG_EN
    logic [W-1:0]   m_in;
    logic           div0;
    logic           mdiv0;
`endif

    int tests  = 0;
    int errors = 0;
    logic [W-1:0] mhi;
    logic [W-1:0] mlo;

    hilo_unit dut (
        .clock   (clock),
        .clear   (clear),
        .start   (start),
        .op      (op),
        .z_in    (z_in),
        .mt_hi   (mt_hi),
        .mt_lo   (mt_lo),
        .mt_data (mt_data),
        .rd_hi   (rd_hi),
        .rd_lo   (rd_lo),
        .hi_out  (hi_out),
        .lo_out  (lo_out),
        .busy    (busy),
        .done    (done),
        .stall   (stall)
`ifdef HILO_DIV0_FLAG_EN
        ,
        .m_in    (m_in),
        .div0    (div0)
`endif
    );

    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        start   = 1'b0;
        op      = T_NONE;
        mt_hi   = 1'b0;
        mt_lo   = 1'b0;
        mt_data = '0;
        rd_hi   = 1'b0;
        rd_lo   = 1'b0;
    endtask

    task automatic test_reset();
        idle();
        z_in    = {$urandom, $urandom};
        clear   = 1'b1;
        mt_hi   = 1'b1;
        mt_lo   = 1'b1;
        mt_data = 32'hDEADBEEF;
        step();
        step();
        clear = 1'b0;
        idle();
        rd_hi = 1'b1;
        #1;
        mhi = '0;
        mlo = '0;
`ifdef HILO_DIV0_FLAG_EN
        mdiv0 = 1'b0;
        m_in  = 32'd1;
        tests++; if (div0 !== 1'b0) begin errors++; $display("FAIL reset_div0: got %b expected 0", div0); end
`endif
        tests++; if (hi_out !== 32'h0) begin errors++; $display("FAIL reset_hi: got %h expected 0", hi_out); end
        tests++; if (lo_out !== 32'h0) begin errors++; $display("FAIL reset_lo: got %h expected 0", lo_out); end
        tests++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        tests++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
        tests++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b expected 0", stall); end
        idle();
    endtask

    task automatic test_div_signed();
        int busy_cnt;
        int done_cnt;
        busy_cnt = 0;
        done_cnt = 0;
        idle();
        op    = T_DIV;
        z_in  = {32'hFFFFFFFF, 32'hFFFFFFFD};
        start = 1'b1;
`ifdef HILO_DIV0_FLAG_EN
        m_in = 32'd2;
`endif
        step();
        start = 1'b0;
        for (int k = 0; k < 8; k++) begin
            if (busy === 1'b1) busy_cnt++;
            if (done === 1'b1) done_cnt++;
            if (k < DIV_L) begin
                tests++; if (busy !== 1'b1) begin errors++; $display("FAIL div_busy_k%0d: got %b expected 1", k, busy); end
            end
            if (k == DIV_L) begin
                tests++; if (done !== 1'b1) begin errors++; $display("FAIL div_done: got %b expected 1", done); end
                tests++; if (hi_out !== 32'hFFFFFFFF) begin errors++; $display("FAIL div_hi: got %h expected FFFFFFFF", hi_out); end
                tests++; if (lo_out !== 32'hFFFFFFFD) begin errors++; $display("FAIL div_lo: got %h expected FFFFFFFD", lo_out); end
            end
            step();
        end
        tests++; if (busy_cnt != DIV_L) begin errors++; $display("FAIL div_busy_cycles: got %0d expected %0d", busy_cnt, DIV_L); end
        tests++; if (done_cnt != 1) begin errors++; $display("FAIL div_done_pulses: got %0d expected 1", done_cnt); end
        mhi = 32'hFFFFFFFF;
        mlo = 32'hFFFFFFFD;
`ifdef HILO_DIV0_FLAG_EN
        mdiv0 = 1'b0;
        tests++; if (div0 !== mdiv0) begin errors++; $display("FAIL div_div0: got %b expected %b", div0, mdiv0); end
`endif
    endtask

    task automatic test_div_zero();
        idle();
        op    = T_DIV;
        z_in  = {32'h00000007, 32'hFFFFFFFF};
        start = 1'b1;
`ifdef HILO_DIV0_FLAG_EN
        m_in = 32'd0;
`endif
        step();
        start = 1'b0;
        for (int k = 0; k < DIV_L; k++) step();
        tests++; if (done !== 1'b1) begin errors++; $display("FAIL div0_done: got %b expected 1", done); end
        tests++; if (hi_out !== 32'h7) begin errors++; $display("FAIL div0_hi: got %h expected 00000007", hi_out); end
        tests++; if (lo_out !== 32'hFFFFFFFF) begin errors++; $display("FAIL div0_lo: got %h expected FFFFFFFF", lo_out); end
        mhi = 32'h7;
        mlo = 32'hFFFFFFFF;
`ifdef HILO_DIV0_FLAG_EN
        mdiv0 = 1'b1;
        tests++; if (div0 !== 1'b1) begin errors++; $display("FAIL div0_flag: got %b expected 1", div0); end
`endif
    endtask

    task automatic test_mul_ignore_start();
        int extra_done;
        int extra_busy;
        extra_done = 0;
        extra_busy = 0;
        idle();
        op    = T_MUL;
        z_in  = {32'h00000001, 32'h80000000};
        start = 1'b1;
`ifdef HILO_DIV0_FLAG_EN
        m_in = 32'd5;
`endif
        step();
        start = 1'b1;
        op    = T_DIV;
        step();
        idle();
        tests++; if (busy !== 1'b1) begin errors++; $display("FAIL mul_busy2: got %b expected 1", busy); end
        step();
        tests++; if (done !== 1'b1) begin errors++; $display("FAIL mul_done: got %b expected 1", done); end
        tests++; if (busy !== 1'b0) begin errors++; $display("FAIL mul_busy_end: got %b expected 0", busy); end
        tests++; if (hi_out !== 32'h1) begin errors++; $display("FAIL mul_hi: got %h expected 00000001", hi_out); end
        tests++; if (lo_out !== 32'h80000000) begin errors++; $display("FAIL mul_lo: got %h expected 80000000", lo_out); end
        mhi = 32'h1;
        mlo = 32'h80000000;
        for (int k = 0; k < 6; k++) begin
            step();
            if (done === 1'b1) extra_done++;
            if (busy === 1'b1) extra_busy++;
        end
        tests++; if (extra_done != 0) begin errors++; $display("FAIL mul_extra_done: got %0d expected 0", extra_done); end
        tests++; if (extra_busy != 0) begin errors++; $display("FAIL mul_extra_busy: got %0d expected 0", extra_busy); end
`ifdef HILO_DIV0_FLAG_EN
        tests++; if (div0 !== mdiv0) begin errors++; $display("FAIL mul_div0_sticky: got %b expected %b", div0, mdiv0); end
`endif
    endtask

    task automatic test_stall();
        logic [2*W-1:0] z;
        z = {$urandom, $urandom};
        idle();
        op    = T_DIV;
        z_in  = z;
        start = 1'b1;
        rd_lo = 1'b1;
`ifdef HILO_DIV0_FLAG_EN
        m_in = 32'd3;
`endif
        #1;
        tests++; if (stall !== 1'b0) begin errors++; $display("FAIL stall_launch: got %b expected 0", stall); end
        step();
        start = 1'b0;
        for (int k = 0; k < DIV_L; k++) begin
            #1;
            tests++; if (stall !== 1'b1) begin errors++; $display("FAIL stall_busy_k%0d: got %b expected 1", k, stall); end
            step();
        end
        tests++; if (stall !== 1'b0) begin errors++; $display("FAIL stall_done_cycle: got %b expected 0", stall); end
        tests++; if (lo_out !== z[W-1:0]) begin errors++; $display("FAIL stall_lo: got %h expected %h", lo_out, z[W-1:0]); end
        mhi = z[2*W-1:W];
        mlo = z[W-1:0];
`ifdef HILO_DIV0_FLAG_EN
        mdiv0 = 1'b0;
`endif
        idle();
    endtask

    task automatic test_clear_mid();
        int done_cnt;
        done_cnt = 0;
        idle();
        op    = T_DIV;
        z_in  = {$urandom, $urandom};
        start = 1'b1;
`ifdef HILO_DIV0_FLAG_EN
        m_in = 32'd0;
`endif
        step();
        start = 1'b0;
        step();
        clear = 1'b1;
        step();
        clear = 1'b0;
        mhi = '0;
        mlo = '0;
        tests++; if (busy !== 1'b0) begin errors++; $display("FAIL clr_busy: got %b expected 0", busy); end
        tests++; if (hi_out !== 32'h0) begin errors++; $display("FAIL clr_hi: got %h expected 0", hi_out); end
        tests++; if (lo_out !== 32'h0) begin errors++; $display("FAIL clr_lo: got %h expected 0", lo_out); end
`ifdef HILO_DIV0_FLAG_EN
        mdiv0 = 1'b0;
        tests++; if (div0 !== 1'b0) begin errors++; $display("FAIL clr_div0: got %b expected 0", div0); end
`endif
        for (int k = 0; k < 6; k++) begin
            if (done === 1'b1) done_cnt++;
            step();
        end
        tests++; if (done_cnt != 0) begin errors++; $display("FAIL clr_no_done: got %0d expected 0", done_cnt); end
        tests++; if (hi_out !== 32'h0) begin errors++; $display("FAIL clr_hi_later: got %h expected 0", hi_out); end
    endtask

    task automatic test_mt_start();
        logic [2*W-1:0] z;
        z = {$urandom, $urandom};
        idle();
        op      = T_DIV;
        z_in    = z;
        start   = 1'b1;
        mt_hi   = 1'b1;
        mt_data = 32'h12345678;
`ifdef HILO_DIV0_FLAG_EN
        m_in = 32'd9;
`endif
        step();
        idle();
        tests++; if (hi_out !== 32'h12345678) begin errors++; $display("FAIL mts_hi_mt: got %h expected 12345678", hi_out); end
        tests++; if (lo_out !== mlo) begin errors++; $display("FAIL mts_lo_kept: got %h expected %h", lo_out, mlo); end
        tests++; if (busy !== 1'b1) begin errors++; $display("FAIL mts_busy: got %b expected 1", busy); end
        for (int k = 1; k < DIV_L; k++) step();
        tests++; if (hi_out !== 32'h12345678) begin errors++; $display("FAIL mts_hi_hold: got %h expected 12345678", hi_out); end
        step();
        tests++; if (hi_out !== z[2*W-1:W]) begin errors++; $display("FAIL mts_hi_cap: got %h expected %h", hi_out, z[2*W-1:W]); end
        tests++; if (lo_out !== z[W-1:0]) begin errors++; $display("FAIL mts_lo_cap: got %h expected %h", lo_out, z[W-1:0]); end
        tests++; if (done !== 1'b1) begin errors++; $display("FAIL mts_done: got %b expected 1", done); end
        mhi = z[2*W-1:W];
        mlo = z[W-1:0];
`ifdef HILO_DIV0_FLAG_EN
        mdiv0 = 1'b0;
`endif
    endtask

    task automatic test_back_to_back();
        logic [2*W-1:0] z;
        logic [1:0]     o;
        int             lat;
        int             n_idle;
        logic [W-1:0]   d;
        logic           wh;
        logic           wl;
        logic           rh;
        logic           rl;
`ifdef HILO_DIV0_FLAG_EN
        logic           zero_div;
`endif
        for (int it = 0; it < 30; it++) begin
            n_idle = $urandom_range(0, 2);
            for (int i = 0; i < n_idle; i++) begin
                wh      = 1'($urandom_range(0, 1));
                wl      = 1'($urandom_range(0, 1));
                d       = $urandom;
                start   = 1'($urandom_range(0, 1));
                op      = ($urandom_range(0, 1) == 0) ? T_NONE : T_RSV;
                mt_hi   = wh;
                mt_lo   = wl;
                mt_data = d;
                rd_hi   = 1'($urandom_range(0, 1));
                rd_lo   = 1'($urandom_range(0, 1));
                #1;
                tests++; if (stall !== 1'b0) begin errors++; $display("FAIL rnd_idle_stall: it %0d got %b expected 0", it, stall); end
                step();
                if (wh) mhi = d;
                if (wl) mlo = d;
                tests++; if (busy !== 1'b0) begin errors++; $display("FAIL rnd_idle_busy: it %0d got %b expected 0", it, busy); end
                tests++; if (done !== 1'b0) begin errors++; $display("FAIL rnd_idle_done: it %0d got %b expected 0", it, done); end
                tests++; if (hi_out !== mhi) begin errors++; $display("FAIL rnd_idle_hi: it %0d got %h expected %h", it, hi_out, mhi); end
                tests++; if (lo_out !== mlo) begin errors++; $display("FAIL rnd_idle_lo: it %0d got %h expected %h", it, lo_out, mlo); end
            end

            idle();
            o       = ($urandom_range(0, 1) == 0) ? T_MUL : T_DIV;
            lat     = (o == T_MUL) ? MUL_L : DIV_L;
            z       = {$urandom, $urandom};
            wh      = 1'($urandom_range(0, 1));
            wl      = 1'($urandom_range(0, 1));
            d       = $urandom;
            start   = 1'b1;
            op      = o;
            z_in    = z;
            mt_hi   = wh;
            mt_lo   = wl;
            mt_data = d;
            rd_lo   = 1'($urandom_range(0, 1));
`ifdef HILO_DIV0_FLAG_EN
            m_in     = ($urandom_range(0, 2) == 0) ? 32'd0 : ($urandom | 32'd1);
            zero_div = (m_in == 32'd0);
`endif
            #1;
            tests++; if (stall !== 1'b0) begin errors++; $display("FAIL rnd_launch_stall: it %0d got %b expected 0", it, stall); end
            step();
            if (wh) mhi = d;
            if (wl) mlo = d;

            for (int k = 0; k < lat; k++) begin
                tests++; if (busy !== 1'b1) begin errors++; $display("FAIL rnd_busy: it %0d k %0d got %b expected 1", it, k, busy); end
                tests++; if (done !== 1'b0) begin errors++; $display("FAIL rnd_busy_done: it %0d k %0d got %b expected 0", it, k, done); end
                tests++; if (hi_out !== mhi) begin errors++; $display("FAIL rnd_busy_hi: it %0d k %0d got %h expected %h", it, k, hi_out, mhi); end
                tests++; if (lo_out !== mlo) begin errors++; $display("FAIL rnd_busy_lo: it %0d k %0d got %h expected %h", it, k, lo_out, mlo); end
                wh      = 1'($urandom_range(0, 1));
                wl      = 1'($urandom_range(0, 1));
                rh      = 1'($urandom_range(0, 1));
                rl      = 1'($urandom_range(0, 1));
                start   = 1'($urandom_range(0, 1));
                op      = 2'($urandom_range(0, 3));
                mt_hi   = wh;
                mt_lo   = wl;
                rd_hi   = rh;
                rd_lo   = rl;
                mt_data = $urandom;
                z_in    = (k == lat - 1) ? z : {$urandom, $urandom};
                #1;
                tests++; if (stall !== (wh | wl | rh | rl)) begin errors++; $display("FAIL rnd_stall: it %0d k %0d got %b expected %b", it, k, stall, (wh | wl | rh | rl)); end
                step();
            end

            mhi = z[2*W-1:W];
            mlo = z[W-1:0];
            tests++; if (done !== 1'b1) begin errors++; $display("FAIL rnd_done: it %0d got %b expected 1", it, done); end
            tests++; if (busy !== 1'b0) begin errors++; $display("FAIL rnd_end_busy: it %0d got %b expected 0", it, busy); end
            tests++; if (hi_out !== mhi) begin errors++; $display("FAIL rnd_cap_hi: it %0d got %h expected %h", it, hi_out, mhi); end
            tests++; if (lo_out !== mlo) begin errors++; $display("FAIL rnd_cap_lo: it %0d got %h expected %h", it, lo_out, mlo); end
`ifdef HILO_DIV0_FLAG_EN
            if (o == T_DIV) mdiv0 = zero_div;
            tests++; if (div0 !== mdiv0) begin errors++; $display("FAIL rnd_div0: it %0d got %b expected %b", it, div0, mdiv0); end
`endif
            idle();
        end
    endtask

    initial begin
        clear = 1'b1;
        z_in  = '0;
        idle();
`ifdef HILO_DIV0_FLAG_EN
        m_in  = '0;
        mdiv0 = 1'b0;
`endif
        mhi = '0;
        mlo = '0;
        test_reset();
        test_div_signed();
        test_div_zero();
        test_mul_ignore_start();
        test_stall();
        test_clear_mid();
        test_mt_start();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
